// File: rtl/pulse_pkg.sv
// Shared types and defaults for the pulse detector / window counter slice.
// Holds the upstream sequence-detector encoding alongside the counter FSM.
package pulse_pkg;

    localparam int PCNT_CNT_W_DEF = 8;
    localparam int PCNT_WIN_DEF   = 1000;

    typedef enum logic {
        IDLE,
        COUNT
    } pcnt_state_t;

    typedef enum logic [1:0] {
        SD_IDLE,
        SD_GOT1,
        SD_GOT10,
        SD_MATCH
    } seqdet_state_t;

endpackage

// File: rtl/pulse_window_counter_if.sv
// Result channel of the window counter: count plus valid/ready handshake
// and the status flags that travel with it.
interface pulse_window_counter_if
    import pulse_pkg::*;
#(
    parameter int CNT_W = PCNT_CNT_W_DEF
);

    logic [CNT_W-1:0] count_out;
    logic             count_valid;
    logic             count_ready;
    logic             saturated;
    logic             overrun;

    modport master (
        output count_out,
        output count_valid,
        output saturated,
        output overrun,
        input  count_ready
    );

    modport slave (
        input  count_out,
        input  count_valid,
        input  saturated,
        input  overrun,
        output count_ready
    );

endinterface

// File: rtl/pulse_edge_detect.sv
// Rising-edge detector: a level held for N cycles yields one pulse.
// Synchronous active-low reset clears the history register.
module pulse_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic pulse_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= in;
        end
    end

    assign rise = in & ~pulse_q;

endmodule

// File: rtl/pulse_window_counter.sv
// Counts detector edges over fixed windows and hands each window's total
// downstream through a one-entry result register with overrun reporting.
module pulse_window_counter
    import pulse_pkg::*;
#(
    parameter int CNT_W      = PCNT_CNT_W_DEF,
    parameter int WIN_CYCLES = PCNT_WIN_DEF,
    parameter int WIN_W      = $clog2(WIN_CYCLES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   pulse_in,
    pulse_window_counter_if.master cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);

    pcnt_state_t      state;
    pcnt_state_t      state_n;
    logic             counting;

    logic             rise;
    logic             bump;
    logic             hit;
    logic             win_end;
    logic             take;

    logic [WIN_W-1:0] timer;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] acc_inc;
    logic             sat;
    logic             sat_inc;

    logic [CNT_W-1:0] res_cnt;
    logic             res_sat;
    logic             res_vld;
    logic             ovr;

    pulse_edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .in    (pulse_in),
        .rise  (rise)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        counting = 1'b0;
        unique case (state)
            IDLE: begin
                if (en) begin
                    state_n = COUNT;
                end
            end
            COUNT: begin
                counting = 1'b1;
                if (!en) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // acc_inc/sat_inc already include this cycle's edge, so at window
    // end they are the closing window's final value.
    assign bump    = counting & rise;
    assign hit     = bump & (acc >= CNT_MAX - CNT_W'(1));
    assign acc_inc = (bump && acc != CNT_MAX) ? acc + CNT_W'(1) : acc;
    assign sat_inc = sat | hit;

    assign win_end = counting & (timer == WIN_LAST);
    assign take    = win_end & (~res_vld | cnt.count_ready);

    always_ff @(posedge clk) begin
        if (!reset || !counting || !en) begin
            timer <= '0;
            acc   <= '0;
            sat   <= 1'b0;
        end else if (win_end) begin
            timer <= '0;
            acc   <= '0;
            sat   <= 1'b0;
        end else begin
            timer <= timer + WIN_W'(1);
            acc   <= acc_inc;
            sat   <= sat_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            res_cnt <= '0;
            res_sat <= 1'b0;
            res_vld <= 1'b0;
            ovr     <= 1'b0;
        end else if (win_end) begin
            if (take) begin
                res_cnt <= acc_inc;
                res_sat <= sat_inc;
                res_vld <= 1'b1;
            end else begin
                ovr     <= 1'b1;
            end
        end else if (res_vld && cnt.count_ready) begin
            res_vld <= 1'b0;
        end
    end

    assign cnt.count_out   = res_cnt;
    assign cnt.saturated   = res_sat;
    assign cnt.count_valid = res_vld;
    assign cnt.overrun     = ovr;

endmodule

// File: doc/pulse_window_counter.md
# pulse_window_counter

Counts rising edges of the single-cycle detection pulse from the sequence-detector stage over fixed windows of `WIN_CYCLES` clocks. At each window end it latches the count into a one-entry result register, which downstream logic drains with a valid/ready handshake. It sits directly downstream of the pulse detector and turns its event stream into per-window rate samples, with saturation and overrun reporting.

## Interface
- `CNT_W`, 8: width of the count accumulator and result.
- `WIN_CYCLES`, 1000: window length in clocks; legal range ≥ 2.
- `WIN_W`, `$clog2(WIN_CYCLES)`: window timer width (derived; do not override).

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `reset`  in  1: synchronous, active-low reset (0 = reset).
- `en`  in  1: counting enable.
- `pulse_in`  in  1: detection pulse from the upstream detector.
- `count_out`  out  CNT_W: latched window count.
- `count_valid`  out  1: `count_out` holds an unconsumed result.
- `count_ready`  in  1: downstream accepts the result.
- `saturated`  out  1: the latched result hit `2^CNT_W-1`; qualified by `count_valid`.
- `overrun`  out  1: sticky flag; a window result was dropped.

## Operation
- Edge detect: `edge = pulse_in & ~pulse_q`, where `pulse_q` is registered. A pulse held high for N cycles counts once.
- FSM states:
  - IDLE: `en`=0; timer and accumulator held at 0.
  - COUNT: `en`=1; timer runs.
  - IDLE→COUNT when `en`=1.
  - COUNT→IDLE when `en`=0. The partial window is discarded; the pending result is kept.
- Accumulator: adds 1 on each edge in COUNT and saturates at `2^CNT_W-1`. It never wraps. A per-window sat bit is set on any saturating edge.
- Window end is the COUNT cycle with timer == `WIN_CYCLES-1`. On that cycle:
  - The timer wraps to 0.
  - The final value is `acc` plus that cycle's edge, saturated.
  - The accumulator and sat bit clear.
- Result register, at window end:
  - If `count_valid`=0, or `count_valid & count_ready` in the same cycle: load the result and sat bit; `count_valid` is 1 next cycle.
  - If `count_valid & ~count_ready`: the new result is dropped, the old result is kept unchanged, and `overrun` is set.
- Handshake: the result transfers on `count_valid & count_ready`. With no new result, `count_valid` is 0 the next cycle. `count_out` and `saturated` are stable while `count_valid & ~count_ready`.
- `overrun` clears only on reset.

## Timing
- Reset (`reset`=0 at a clk edge) forces the next cycle to:
  - state IDLE, timer 0, `acc` 0, `pulse_q` 0;
  - `count_out` 0, `count_valid` 0, `saturated` 0, `overrun` 0.
- Reset mid-window or mid-handshake discards everything; there is no partial report.
- The first window starts on the first cycle sampled in COUNT. If `en` rises at edge k, the window covers cycles k+1 … k+`WIN_CYCLES` and `count_valid` rises at k+`WIN_CYCLES`+1.
- Latency is one clock from window-end cycle to `count_valid` high. An edge on the window-end cycle belongs to the closing window.
- `pulse_in` is synchronous to `clk`; no synchronizer is included.

## Structure
- Package `pulse_pkg`:
  - typedef enum `pcnt_state_t` {IDLE, COUNT};
  - shared defaults `PCNT_CNT_W_DEF` and `PCNT_WIN_DEF`.
  - The upstream detector's state encoding also moves into this package.
- Sub-module `pulse_edge_detect`: `clk`, `reset`, `in`, `edge`, with the same reset rules. The top instantiates it once.

## Test plan
All scenarios use `CNT_W`=3 and `WIN_CYCLES`=16 unless stated otherwise.
- Reset: hold `reset`=0 for 3 cycles with `pulse_in` toggling → all outputs 0; no `count_valid` for 16 cycles after release with `en`=0.
- Basic count: `en` rises at cycle 0; 5 one-cycle pulses at cycles 2,4,6,8,10; `count_ready`=1 → `count_out`=5, `count_valid` high exactly at cycle 17 for one cycle, `saturated`=0.
- Level, boundary and wrap:
  - `pulse_in` high for cycles 3–12 → count 1.
  - A single pulse on the window-end cycle (cycle 16) → count 1 in that window and 0 in the next.
  - Timer wrap: the next window's `count_valid` rises at cycle 33.
- Saturation: 8 edges in one window (alternate cycles) → `count_out`=7, `saturated`=1. The next window with 2 edges gives `count_out`=2, `saturated`=0.
- Backpressure and overrun:
  - `count_ready`=0 for 40 cycles with 3 edges in window 1 and 4 in window 2 → `count_out` stays 3, `overrun`=1 after the second window end.
  - Raising `count_ready` → one transfer of 3; `overrun` stays 1.
  - Simultaneous accept and window end → the new value loads and `count_valid` stays high.
- Enable drop and mid-operation reset:
  - `en` low at cycle 8 after 2 edges → no report; `en` back high restarts a full 16-cycle window.
  - `reset`=0 at cycle 10 with a result pending → `count_valid`=0 next cycle.
